// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// grant encodings, default starvation limit and a small grant helper.
package mem_port_arbiter_pkg;

  // Grant / response-owner encoding shared by the grant mux and response tracker.
  typedef enum logic [1:0] {
    ARB_GNT_NONE = 2'd0,
    ARB_GNT_IF   = 2'd1,
    ARB_GNT_DM   = 2'd2
  } arb_gnt_e;

  // Default number of back-to-back data grants tolerated while fetch waits.
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  // Owner of the read response produced by a grant; NONE for writes and idle cycles.
  function automatic arb_gnt_e resp_owner_of(input arb_gnt_e gnt, input logic dm_we);
    arb_gnt_e owner;
    case (gnt)
      ARB_GNT_IF: owner = ARB_GNT_IF;
      ARB_GNT_DM: owner = dm_we ? ARB_GNT_NONE : ARB_GNT_DM;
      default:    owner = ARB_GNT_NONE;
    endcase
    return owner;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Starvation guard for the memory arbiter: counts consecutive data grants
// while fetch is waiting and raises fire once the limit is reached.
// Only instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic gnt_if,
  input  logic gnt_dm,
  output logic fire
);

  localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_d;
  logic [CNT_W-1:0] starve_cnt_q;

  // Next count: clear when fetch is served or idle, saturate at the limit on data grants.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (gnt_if || !if_req) begin
      starve_cnt_d = '0;
    end else if (gnt_dm && (starve_cnt_q != LIMIT_C)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1'b1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign fire = (starve_cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous memory between instruction
// fetch (if_*) and data access (dm_*). Data has priority; the optional
// starvation guard (macro MEM_ARB_STARVE_GUARD_EN) lets fetch win after
// STARVE_LIMIT consecutive data grants. Read data returns one cycle after
// the grant and is steered to its owner by the registered resp_owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_gnt_e gnt_s;
  arb_gnt_e resp_owner_d;
  arb_gnt_e resp_owner_q;
  logic     starve_fire_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk    (clk),
    .reset  (reset),
    .if_req (if_req),
    .gnt_if (gnt_s == ARB_GNT_IF),
    .gnt_dm (gnt_s == ARB_GNT_DM),
    .fire   (starve_fire_s)
  );
`else
  assign starve_fire_s = 1'b0;
`endif

  // Grant selection: data wins contention unless the starvation guard fires; nothing during reset.
  always_comb begin
    gnt_s = ARB_GNT_NONE;
    if (reset) begin
      gnt_s = ARB_GNT_NONE;
    end else if (if_req && dm_req) begin
      gnt_s = starve_fire_s ? ARB_GNT_IF : ARB_GNT_DM;
    end else if (dm_req) begin
      gnt_s = ARB_GNT_DM;
    end else if (if_req) begin
      gnt_s = ARB_GNT_IF;
    end else begin
      gnt_s = ARB_GNT_NONE;
    end
  end

  // Memory command mux driven from the granted port; idle cycles present all zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (gnt_s)
      ARB_GNT_IF: begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end
      ARB_GNT_DM: begin
        mem_en    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end
      default: begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
  end

  // Next response owner: the read granted this cycle, if any.
  always_comb begin
    resp_owner_d = resp_owner_of(gnt_s, dm_we);
  end

  // Response owner register; a single response is in flight at most.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_owner_q <= ARB_GNT_NONE;
    end else begin
      resp_owner_q <= resp_owner_d;
    end
  end

  assign if_ready  = (gnt_s == ARB_GNT_IF);
  assign dm_ready  = (gnt_s == ARB_GNT_DM);

  // A read granted just before reset rises is dropped: reset masks the retiring response.
  assign if_rvalid = (resp_owner_q == ARB_GNT_IF) && !reset;
  assign dm_rvalid = (resp_owner_q == ARB_GNT_DM) && !reset;

  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

endmodule
